// File: rtl/wm_phase_timer.sv
// wm_phase_timer: loads the mode-scaled duration of the selected phase, counts it down in prescaled ticks, and raises timer_done.
// Define WM_LID_PAUSE_EN to make an open lid pause the countdown while it is running.
module wm_phase_timer #(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 12,
    parameter int SOAK_T   = 8,
    parameter int WASH_T   = 16,
    parameter int RINSE_T  = 8,
    parameter int SPIN_T   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             timer_enable,
    input  logic [1:0]       phase_sel,
    input  logic             mode1,
    input  logic             mode2,
    input  logic             mode3,
    input  logic             lid,
    input  logic             cancel,
    output logic             timer_done,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             paused
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] PAUSE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [63:0] MAXV = (64'd1 << CNT_W) - 64'd1;

    logic [2:0]       state, state_nx;
    logic [PW-1:0]    pre;
    logic [1:0]       phase;
    logic [1:0]       mult;
    logic [63:0]      base, prod;
    logic [CNT_W-1:0] load_val;
    logic             tick, lid_stop;

    assign mult = mode3 ? 2'd3 : mode2 ? 2'd2 : 2'd1;
    assign base = phase_sel == 2'b00 ? 64'(SOAK_T) :
                  phase_sel == 2'b01 ? 64'(WASH_T) :
                  phase_sel == 2'b10 ? 64'(RINSE_T) : 64'(SPIN_T);
    assign prod = base * {62'd0, mult};
    assign load_val = prod > MAXV ? CNT_W'(MAXV) : CNT_W'(prod);
    assign tick = pre == PRE_MAX;

`ifdef WM_LID_PAUSE_EN
    assign lid_stop = lid;
    assign paused   = state == PAUSE;
`else
    assign lid_stop = 1'b0;
    assign paused   = 1'b0;
`endif

    // Phase change beats expiry, expiry beats lid pause
    always_comb begin
        state_nx = state;
        if (cancel || !timer_enable)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = LOAD;
                LOAD:    state_nx = load_val == '0 ? DONE : RUN;
                RUN:     state_nx = phase_sel != phase ? LOAD : remaining == '0 ? DONE : lid_stop ? PAUSE : RUN;
                PAUSE:   state_nx = lid ? PAUSE : RUN;
                DONE:    state_nx = lid ? DONE : LOAD;
                default: state_nx = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pre       <= '0;
            phase     <= 2'b00;
            remaining <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == IDLE) begin
                remaining <= '0;
                pre       <= '0;
            end else if (state == LOAD) begin
                remaining <= load_val;
                phase     <= phase_sel;
                pre       <= '0;
            end else if (state == RUN) begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick && remaining != '0)
                    remaining <= remaining - 1'b1;
            end else if (state == DONE) begin
                remaining <= '0;
            end
        end
    end

    assign timer_done = state == DONE;
    assign busy       = state != IDLE;
endmodule

// File: tb/tb_wm_phase_timer.sv
// tb_wm_phase_timer: scoreboarded checks of load values, tick latency, lid pause/hold, cancel and reset.
// Lid-pause expectations follow WM_LID_PAUSE_EN the same way the design does.
module tb_wm_phase_timer;
    localparam int TD = 4;
`ifdef WM_LID_PAUSE_EN
    localparam logic PX = 1'b1;
    localparam int PAUSE_DLY = 20;
`else
    localparam logic PX = 1'b0;
    localparam int PAUSE_DLY = 0;
`endif

    logic clk = 0, rst_n = 0, timer_enable = 0, mode1 = 0, mode2 = 0, mode3 = 0, lid = 0, cancel = 0;
    logic [1:0] phase_sel = 2'b00;
    logic timer_done, busy, paused, done0, busy0, paused0;
    logic [11:0] remaining, rem0, r1;
    int cyc = 0, total = 0, bad = 0, c0, exp_cyc;
    int exp_q[$];

    wm_phase_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .timer_enable(timer_enable), .phase_sel(phase_sel),
        .mode1(mode1), .mode2(mode2), .mode3(mode3), .lid(lid), .cancel(cancel),
        .timer_done(timer_done), .remaining(remaining), .busy(busy), .paused(paused)
    );

    wm_phase_timer #(.TICK_DIV(TD), .WASH_T(0), .SOAK_T(2000)) dut0 (
        .clk(clk), .rst_n(rst_n), .timer_enable(timer_enable), .phase_sel(phase_sel),
        .mode1(mode1), .mode2(mode2), .mode3(mode3), .lid(lid), .cancel(cancel),
        .timer_done(done0), .remaining(rem0), .busy(busy0), .paused(paused0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_rem(input int n, input int m);
        return n - m / TD;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic go_idle();
        timer_enable = 0;
        cancel = 0;
        lid = 0;
        step();
    endtask

    // c0 is the edge that first samples timer_enable
    task automatic start(input logic [1:0] ph, input int m, output int c);
        phase_sel = ph;
        mode1 = m == 1;
        mode2 = m == 2;
        mode3 = m == 3;
        timer_enable = 1;
        c = cyc + 1;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !timer_done; i++) step();
    endtask

    task automatic test_reset();
        steps(2);
        total++; if (remaining !== 12'd0) begin bad++; $display("FAIL reset_rem: got %0d want 0", remaining); end
        total++; if ({timer_done, busy, paused} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {timer_done, busy, paused}); end
        rst_n = 1;
        step();
    endtask

    task automatic test_wash();
        go_idle();
        start(2'b01, 2, c0);
        exp_q.push_back(c0 + 2 + 32 * TD);
        steps(2);
        total++; if (remaining !== 12'd32) begin bad++; $display("FAIL wash_load: got %0d want 32", remaining); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wash_busy: got %b want 1", busy); end
        wait_done(200);
        exp_cyc = exp_q.pop_front();
        total++; if (cyc !== exp_cyc || timer_done !== 1'b1) begin bad++; $display("FAIL wash_done: got edge %0d done %b want edge %0d done 1", cyc, timer_done, exp_cyc); end
        step();
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL wash_pulse: got %b want 0", timer_done); end
    endtask

    task automatic test_pause();
        go_idle();
        start(2'b00, 3, c0);
        exp_q.push_back(c0 + 2 + 24 * TD + PAUSE_DLY);
        steps(31);
        total++; if (remaining !== 12'(exp_rem(24, 29))) begin bad++; $display("FAIL pause_pre: got %0d want %0d", remaining, exp_rem(24, 29)); end
        lid = 1;
        step();
        r1 = remaining;
        total++; if (paused !== PX) begin bad++; $display("FAIL pause_flag: got %b want %b", paused, PX); end
        total++; if (r1 !== 12'(exp_rem(24, 30))) begin bad++; $display("FAIL pause_entry: got %0d want %0d", r1, exp_rem(24, 30)); end
        steps(19);
        exp_cyc = PX ? int'(r1) : exp_rem(24, 49);
        total++; if (remaining !== 12'(exp_cyc)) begin bad++; $display("FAIL pause_hold: got %0d want %0d", remaining, exp_cyc); end
        lid = 0;
        wait_done(300);
        exp_cyc = exp_q.pop_front();
        total++; if (cyc !== exp_cyc || timer_done !== 1'b1) begin bad++; $display("FAIL pause_done: got edge %0d done %b want edge %0d done 1", cyc, timer_done, exp_cyc); end
    endtask

    task automatic test_lid_done();
        go_idle();
        start(2'b10, 1, c0);
        exp_q.push_back(c0 + 2 + 8 * TD);
        steps(34);
        total++; if (remaining !== 12'd0 || timer_done !== 1'b0) begin bad++; $display("FAIL rinse_zero: got rem %0d done %b want rem 0 done 0", remaining, timer_done); end
        lid = 1;
        step();
        exp_cyc = exp_q.pop_front();
        total++; if (cyc !== exp_cyc || timer_done !== 1'b1) begin bad++; $display("FAIL rinse_done: got edge %0d done %b want edge %0d done 1", cyc, timer_done, exp_cyc); end
        steps(3);
        total++; if (timer_done !== 1'b1 || paused !== 1'b0) begin bad++; $display("FAIL rinse_hold: got done %b paused %b want done 1 paused 0", timer_done, paused); end
        lid = 0;
        step();
        total++; if (timer_done !== 1'b0) begin bad++; $display("FAIL rinse_release: got %b want 0", timer_done); end
        phase_sel = 2'b11;
        step();
        total++; if (remaining !== 12'd4) begin bad++; $display("FAIL spin_load: got %0d want 4", remaining); end
        exp_q.push_back(cyc + 1 + 4 * TD);
        wait_done(100);
        exp_cyc = exp_q.pop_front();
        total++; if (cyc !== exp_cyc || timer_done !== 1'b1) begin bad++; $display("FAIL spin_done: got edge %0d done %b want edge %0d done 1", cyc, timer_done, exp_cyc); end
        timer_enable = 0;
        step();
        total++; if ({timer_done, busy} !== 2'b00 || remaining !== 12'd0) begin bad++; $display("FAIL spin_idle: got done %b busy %b rem %0d want 0 0 0", timer_done, busy, remaining); end
    endtask

    task automatic test_cancel();
        go_idle();
        start(2'b01, 1, c0);
        steps(26);
        total++; if (remaining !== 12'(exp_rem(16, 24))) begin bad++; $display("FAIL cancel_pre: got %0d want %0d", remaining, exp_rem(16, 24)); end
        cancel = 1;
        step();
        total++; if ({timer_done, busy} !== 2'b00 || remaining !== 12'd0) begin bad++; $display("FAIL cancel_idle: got done %b busy %b rem %0d want 0 0 0", timer_done, busy, remaining); end
        cancel = 0;
        timer_enable = 0;
    endtask

    task automatic test_reset_mid();
        go_idle();
        start(2'b01, 2, c0);
        steps(20);
        total++; if (remaining !== 12'(exp_rem(32, 18))) begin bad++; $display("FAIL rst_pre: got %0d want %0d", remaining, exp_rem(32, 18)); end
        #2 rst_n = 0;
        #1;
        total++; if ({timer_done, busy, paused} !== 3'b000 || remaining !== 12'd0) begin bad++; $display("FAIL rst_async: got flags %b rem %0d want 000 0", {timer_done, busy, paused}, remaining); end
        step();
        rst_n = 1;
        for (int m = 1; m <= 3; m++) begin
            timer_enable = 0;
            step();
            start(2'b01, m, c0);
            steps(2);
            total++; if (remaining !== 12'(16 * m)) begin bad++; $display("FAIL rst_reload%0d: got %0d want %0d", m, remaining, 16 * m); end
        end
    endtask

    task automatic test_edge_loads();
        go_idle();
        start(2'b01, 1, c0);
        steps(2);
        total++; if (done0 !== 1'b1 || rem0 !== 12'd0) begin bad++; $display("FAIL zero_load: got done %b rem %0d want done 1 rem 0", done0, rem0); end
        total++; if (remaining !== 12'd16) begin bad++; $display("FAIL zero_peer: got %0d want 16", remaining); end
        go_idle();
        start(2'b00, 3, c0);
        steps(2);
        total++; if (rem0 !== 12'd4095) begin bad++; $display("FAIL sat_load: got %0d want 4095", rem0); end
    endtask

    initial begin
        test_reset();
        test_wash();
        test_pause();
        test_lid_done();
        test_cancel();
        test_reset_mid();
        test_edge_loads();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
